audio_clk_sequencer: RTL
========================

# audio_clk_sequencer

Generates the I2S serial bit clock (bclk) and word-select clock (lrclk) from the master clock clkIn. Divide ratios are programmable, and new ratios are applied only at frame boundaries, so bclk and lrclk never glitch. Start and stop are frame-aligned. The block sits between the master clock source and the serializer/deserializer blocks of the channel strip, which use the bclk_fall_en and frame_start strobes as clock enables.

## Interface

- HALF_W, default 8: width of the bclk half-period field.
- BITS_W, default 6: width of the bits-per-channel field.
- DEF_HALF, default 4: active bclk half-period after reset, in clkIn cycles.
- DEF_BITS, default 32: active bclk cycles per lrclk half-frame after reset.

- clkIn  input  1  master clock; all logic is on the rising edge.
- reset_n  input  1  reset, asynchronous, active-low.
- enable  input  1  run request; level-sensitive.
- cfg_valid  input  1  a new configuration is offered.
- cfg_ready  output  1  the block can accept a configuration.
- cfg_half  input  HALF_W  bclk half-period in clkIn cycles; 0 is clamped to 1.
- cfg_bits  input  BITS_W  bclk cycles per channel; 0 is clamped to 1.
- bclk  output  1  bit clock, registered.
- lrclk  output  1  word select, registered: 0 = left, 1 = right.
- bclk_fall_en  output  1  one-cycle pulse in the cycle bclk goes 1->0.
- frame_start  output  1  one-cycle pulse at the start of each left half-frame.
- busy  output  1  state is not IDLE.

## Operation

- State machine states:
  - IDLE: bclk = 0, lrclk = 0, counters = 0.
  - RUN: clocks toggle continuously.
  - STOP: clocks keep running until the end of the current frame.
- Transitions:
  - IDLE -> RUN when enable = 1.
  - RUN -> STOP when enable = 0.
  - STOP -> RUN when enable = 1 before the frame boundary. The clocks are not interrupted.
  - STOP -> IDLE at the frame boundary.
- Half-period counter hc runs 0..act_half-1. When hc = act_half-1, hc wraps to 0 and bclk toggles.
- Bit counter bc increments on every bclk 1->0 transition. When bc = act_bits-1 at such a transition, bc wraps to 0 and lrclk toggles.
- Frame boundary: the bclk 1->0 transition at which lrclk goes 1->0. One frame is 2·act_bits bclk periods, which is 4·act_half·act_bits clkIn cycles.
- Configuration handshake:
  - The handshake completes when cfg_valid = 1 and cfg_ready = 1.
  - On acceptance, cfg_half and cfg_bits are clamped and captured into a shadow register, the pending flag is set, and cfg_ready goes to 0.
  - In IDLE, the shadow is copied to the active configuration on the next clock.
  - In RUN or STOP, the shadow is copied at the frame boundary, and the new values govern the very next clkIn cycle.
  - The pending flag clears, and cfg_ready returns to 1, in the cycle after the copy.
- Widths: hc is HALF_W bits and bc is BITS_W bits. Comparisons are unsigned. No counter exceeds its active limit, so there is no overflow.
- Reset values: bclk = 0, lrclk = 0, bclk_fall_en = 0, frame_start = 0, busy = 0, cfg_ready = 1, state = IDLE, active configuration = DEF_HALF/DEF_BITS, pending flag = 0.

## Timing

- Start: enable rises in cycle T, so state = RUN in T+1. frame_start = 1 in T+1, with bclk = 0 and lrclk = 0 in that cycle. The first bclk rise occurs in T+act_half+1.
- frame_start is asserted in the same cycle that lrclk is registered 1->0, and in the first RUN cycle after IDLE.
- bclk_fall_en is asserted in the same cycle that the registered bclk becomes 0.
- Stop: the cycle after the frame boundary shows bclk = 0, lrclk = 0, and busy = 0. No partial frame is ever emitted.
- Simultaneous events:
  - enable falling at the frame boundary: the block goes to STOP, and IDLE follows only at the next boundary.
  - cfg acceptance in the same cycle as a boundary: the new values are not applied until the following boundary.
- Reset mid-operation: all outputs go to their reset values immediately (asynchronously). The pending configuration is discarded.

## Test plan

- Reset defaults: after reset, enable = 1 -> bclk period 8 clkIn, lrclk period 512 clkIn, one frame_start pulse every 512 cycles, with bclk = lrclk = 0 at each pulse.
- Mid-frame reconfiguration: in RUN with default configuration, offer cfg_half = 2, cfg_bits = 4 mid-frame -> cfg_ready low until one cycle after the next boundary. The current frame completes at 512 cycles, and subsequent frames are 32 clkIn with bclk period 4.
- Frame-aligned stop: enable = 0 mid-frame -> bclk keeps toggling until the lrclk 1->0 transition, then bclk = lrclk = busy = 0. The count of bclk_fall_en pulses per frame is exactly 2·act_bits.
- Clamping: cfg_half = 0, cfg_bits = 0 accepted in IDLE -> bclk period 2 clkIn, lrclk toggles every 2 clkIn.
- Resume from STOP: enable dropped then re-raised before the boundary -> no gap in bclk, busy stays 1, frame_start pulses at the normal boundary.
- Reset mid-frame: assert reset_n low with a configuration pending -> outputs are 0 and cfg_ready = 1 immediately. After release, the default timing is restored.

Source files
------------

// File: rtl/audio_clk_sequencer.sv
// I2S bit-clock / word-select generator with frame-aligned start, stop and
// reconfiguration, driven entirely from the master clock clkIn.
module audio_clk_sequencer #(
  parameter int HALF_W   = 8,
  parameter int BITS_W   = 6,
  parameter int DEF_HALF = 4,
  parameter int DEF_BITS = 32
) (
  input  logic              clkIn,
  input  logic              reset_n,
  input  logic              enable,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [HALF_W-1:0] cfg_half,
  input  logic [BITS_W-1:0] cfg_bits,
  output logic              bclk,
  output logic              lrclk,
  output logic              bclk_fall_en,
  output logic              frame_start,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, RUN, STOP} state_t;

  state_t            state, state_next;
  logic [HALF_W-1:0] hc, act_half, shadow_half;
  logic [BITS_W-1:0] bc, act_bits, shadow_bits;
  logic              pending;
  logic              running, hc_wrap, bc_last, bclk_fall, boundary;
  logic              accept, apply_cfg;

  assign running   = (state != IDLE);
  assign hc_wrap   = (hc == act_half - HALF_W'(1));
  assign bc_last   = (bc == act_bits - BITS_W'(1));
  assign bclk_fall = running && hc_wrap && bclk;
  // The frame boundary is the bclk fall that also returns lrclk to left.
  assign boundary  = bclk_fall && bc_last && lrclk;
  assign accept    = cfg_valid && !pending;
  assign apply_cfg = pending && (!running || boundary);
  assign cfg_ready = !pending;
  assign busy      = running;

  always_ff @(posedge clkIn or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (enable) state_next = RUN;
      RUN:     if (!enable) state_next = STOP;
      STOP: begin
        if (enable)        state_next = RUN;
        else if (boundary) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clkIn or negedge reset_n) begin
    if (!reset_n) begin
      hc           <= '0;
      bc           <= '0;
      bclk         <= 1'b0;
      lrclk        <= 1'b0;
      bclk_fall_en <= 1'b0;
      frame_start  <= 1'b0;
    end else begin
      frame_start  <= (state == IDLE && enable) || boundary;
      bclk_fall_en <= bclk_fall;
      if (!running) begin
        hc    <= '0;
        bc    <= '0;
        bclk  <= 1'b0;
        lrclk <= 1'b0;
      end else if (hc_wrap) begin
        hc   <= '0;
        bclk <= ~bclk;
        if (bclk) begin
          if (bc_last) begin
            bc    <= '0;
            lrclk <= ~lrclk;
          end else begin
            bc <= bc + BITS_W'(1);
          end
        end
      end else begin
        hc <= hc + HALF_W'(1);
      end
    end
  end

  // Acceptance needs pending low and a copy needs it high, so they never coincide.
  always_ff @(posedge clkIn or negedge reset_n) begin
    if (!reset_n) begin
      act_half    <= HALF_W'(DEF_HALF);
      act_bits    <= BITS_W'(DEF_BITS);
      shadow_half <= HALF_W'(DEF_HALF);
      shadow_bits <= BITS_W'(DEF_BITS);
      pending     <= 1'b0;
    end else begin
      if (apply_cfg) begin
        act_half <= shadow_half;
        act_bits <= shadow_bits;
        pending  <= 1'b0;
      end
      if (accept) begin
        shadow_half <= (cfg_half == '0) ? HALF_W'(1) : cfg_half;
        shadow_bits <= (cfg_bits == '0) ? BITS_W'(1) : cfg_bits;
        pending     <= 1'b1;
      end
    end
  end

endmodule
